pix_window_2x2: RTL and testbench

- Upstream stage of the min-reduction datapath.
- Accepts a raster-order 8-bit grayscale pixel stream, one pixel per beat, row 0 first and left to right within a row.
- Assembles non-overlapping 2x2 blocks and emits each block as one packed 32-bit word for the combinational reduction stage.
- Internal storage: one half-line buffer for the even row plus one holding register.

---
 rtl/pix_pkg.sv | 25 ++
 rtl/pix_line_buf.sv | 33 +++
 rtl/pix_window_2x2.sv | 167 ++++++++++++++++
 tb/tb_pix_window_2x2.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pix_pkg.sv
// Shared constants and types for the 2x2 pixel window stage of the
// min-reduction datapath.
package pix_pkg;

    localparam int PIX_W      = 8;
    localparam int WIDTH_DEF  = 160;
    localparam int HEIGHT_DEF = 120;

    typedef logic [PIX_W-1:0] pix_t;

    // Field order mirrors the packed output word: p00 sits in the low lane.
    typedef struct packed {
        pix_t p11;
        pix_t p10;
        pix_t p01;
        pix_t p00;
    } blk_t;

    // Lane positions inside the packed 4*PIX_W block word.
    localparam int LANE_P00 = 0;
    localparam int LANE_P01 = 1;
    localparam int LANE_P10 = 2;
    localparam int LANE_P11 = 3;

endpackage

// File: rtl/pix_line_buf.sv
// Half-line buffer for the even row: single-port synchronous RAM holding
// one pixel pair per word, with a registered read port.
module pix_line_buf
    import pix_pkg::*;
#(
    parameter int DEPTH = WIDTH_DEF / 2,
    parameter int DW    = 2 * PIX_W,
    parameter int AW    = 7
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic          re_i,
    input  logic [AW-1:0] addr_i,
    input  logic [DW-1:0] wdata_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] rdata_q;

    // Write the pair on even rows; capture the read word one beat before use.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/pix_window_2x2.sv
// Collects a raster pixel stream into non-overlapping 2x2 blocks and emits
// each block as one packed word with end-of-line / end-of-frame markers.
module pix_window_2x2
    import pix_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int HEIGHT = HEIGHT_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [PIX_W-1:0]   s_data,
    input  logic               s_sof,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [4*PIX_W-1:0] m_data,
    output logic               m_eol,
    output logic               m_eof,
    output logic               frame_err
);

    localparam int CW       = $clog2(WIDTH);
    localparam int RW       = $clog2(HEIGHT);
    localparam int LB_DEPTH = WIDTH / 2;
    localparam int AW       = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;

    localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);

    logic [CW-1:0]        col_q, col_d;
    logic [RW-1:0]        row_q, row_d;
    pix_t                 pend_q, pend_d;
    pix_t                 hold_q, hold_d;
    logic                 m_valid_q, m_valid_d;
    logic [4*PIX_W-1:0]   m_data_q, m_data_d;
    logic                 m_eol_q, m_eol_d;
    logic                 m_eof_q, m_eof_d;
    logic                 err_q, err_d;

    logic                 sReady;
    logic                 inBeat;
    logic [CW-1:0]        colEff;
    logic [RW-1:0]        rowEff;
    logic                 colOdd;
    logic                 rowOdd;
    logic                 blkFire;
    logic                 lbWe;
    logic                 lbRe;
    logic [AW-1:0]        lbAddr;
    logic [2*PIX_W-1:0]   lbWdata;
    logic [2*PIX_W-1:0]   lbRdata;
    logic [4*PIX_W-1:0]   blkWord;

    // Accept handshake and SOF realignment: an SOF pixel always lands at (0,0).
    always_comb begin
        sReady  = !m_valid_q || m_ready;
        inBeat  = s_valid && sReady;
        colEff  = s_sof ? '0 : col_q;
        rowEff  = s_sof ? '0 : row_q;
        colOdd  = colEff[0];
        rowOdd  = rowEff[0];
        blkFire = inBeat && rowOdd && colOdd;
        lbWe    = inBeat && !rowOdd && colOdd;
        lbRe    = inBeat && rowOdd && !colOdd;
        lbAddr  = AW'(colEff >> 1);
        lbWdata = {s_data, pend_q};
    end

    // Packed block: even-row pair from the buffer, odd-row pair from hold + live pixel.
    always_comb begin
        blkWord = '0;
        blkWord[LANE_P00*PIX_W +: PIX_W] = lbRdata[PIX_W-1:0];
        blkWord[LANE_P01*PIX_W +: PIX_W] = lbRdata[2*PIX_W-1:PIX_W];
        blkWord[LANE_P10*PIX_W +: PIX_W] = hold_q;
        blkWord[LANE_P11*PIX_W +: PIX_W] = s_data;
    end

    // Raster position tracking, pixel staging and the sticky SOF error.
    always_comb begin
        col_d  = col_q;
        row_d  = row_q;
        pend_d = pend_q;
        hold_d = hold_q;
        err_d  = err_q;
        if (inBeat) begin
            if (colEff == COL_LAST) begin
                col_d = '0;
                row_d = (rowEff == ROW_LAST) ? '0 : rowEff + RW'(1);
            end else begin
                col_d = colEff + CW'(1);
                row_d = rowEff;
            end
            if (!rowOdd && !colOdd) begin
                pend_d = s_data;
            end
            if (rowOdd && !colOdd) begin
                hold_d = s_data;
            end
            if (s_sof && (col_q != '0 || row_q != '0)) begin
                err_d = 1'b1;
            end
        end
    end

    // Output register: load on a completed block, drop valid once consumed.
    always_comb begin
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        m_eol_d   = m_eol_q;
        m_eof_d   = m_eof_q;
        if (blkFire) begin
            m_valid_d = 1'b1;
            m_data_d  = blkWord;
            m_eol_d   = (colEff == COL_LAST);
            m_eof_d   = (colEff == COL_LAST) && (rowEff == ROW_LAST);
        end else if (m_ready) begin
            m_valid_d = 1'b0;
        end
    end

    // State update with synchronous active-low reset; the line buffer is not cleared.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col_q     <= '0;
            row_q     <= '0;
            pend_q    <= '0;
            hold_q    <= '0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_eol_q   <= 1'b0;
            m_eof_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            col_q     <= col_d;
            row_q     <= row_d;
            pend_q    <= pend_d;
            hold_q    <= hold_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_eol_q   <= m_eol_d;
            m_eof_q   <= m_eof_d;
            err_q     <= err_d;
        end
    end

    pix_line_buf #(
        .DEPTH (LB_DEPTH),
        .DW    (2 * PIX_W),
        .AW    (AW)
    ) u_line_buf (
        .clk_i   (clk),
        .we_i    (lbWe),
        .re_i    (lbRe),
        .addr_i  (lbAddr),
        .wdata_i (lbWdata),
        .rdata_o (lbRdata)
    );

    assign s_ready   = sReady;
    assign m_valid   = m_valid_q;
    assign m_data    = m_data_q;
    assign m_eol     = m_eol_q;
    assign m_eof     = m_eof_q;
    assign frame_err = err_q;

endmodule

// File: tb/tb_pix_window_2x2.sv
// Directed bench for pix_window_2x2: a 4x2 instance for handshake, SOF and
// reset corner cases, and a default 160x120 instance for whole-frame streams.
module tb_pix_window_2x2;
    import pix_pkg::*;

    localparam int BG_W   = 160;
    localparam int BG_H   = 120;
    localparam int BG_BPF = (BG_W / 2) * (BG_H / 2);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // small 4x2 instance
    logic        smRstN;
    logic        smSValid;
    logic        smSReady;
    logic [7:0]  smSData;
    logic        smSSof;
    logic        smMValid;
    logic        smMReady;
    logic [31:0] smMData;
    logic        smMEol;
    logic        smMEof;
    logic        smFrameErr;

    // default 160x120 instance
    logic        bgRstN;
    logic        bgSValid;
    logic        bgSReady;
    logic [7:0]  bgSData;
    logic        bgSSof;
    logic        bgMValid;
    logic        bgMReady;
    logic [31:0] bgMData;
    logic        bgMEol;
    logic        bgMEof;
    logic        bgFrameErr;
    bit          bgRandReady = 1'b0;

    int          bgBlk   = 0;
    logic [31:0] bgBlk82 = '0;
    int          monK, monR, monC;
    blk_t        expBlk;
    logic        expEol, expEof;

    pix_window_2x2 #(.WIDTH(4), .HEIGHT(2)) u_small (
        .clk       (clk),
        .rst_n     (smRstN),
        .s_valid   (smSValid),
        .s_ready   (smSReady),
        .s_data    (smSData),
        .s_sof     (smSSof),
        .m_valid   (smMValid),
        .m_ready   (smMReady),
        .m_data    (smMData),
        .m_eol     (smMEol),
        .m_eof     (smMEof),
        .frame_err (smFrameErr)
    );

    pix_window_2x2 u_big (
        .clk       (clk),
        .rst_n     (bgRstN),
        .s_valid   (bgSValid),
        .s_ready   (bgSReady),
        .s_data    (bgSData),
        .s_sof     (bgSSof),
        .m_valid   (bgMValid),
        .m_ready   (bgMReady),
        .m_data    (bgMData),
        .m_eol     (bgMEol),
        .m_eof     (bgMEof),
        .frame_err (bgFrameErr)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [7:0] bgPix(input int r, input int c);
        return 8'((r * BG_W + c) % 256);
    endfunction

    // One pixel into the small instance; called just after a rising edge.
    task automatic applyStimulus(input logic [7:0] pix, input logic sof);
        smSValid = 1'b1;
        smSData  = pix;
        smSSof   = sof;
        @(posedge clk);
        #1;
        smSValid = 1'b0;
        smSSof   = 1'b0;
    endtask

    // One pixel into the default instance, optionally after an idle cycle.
    task automatic applyBigStimulus(input logic [7:0] pix, input logic sof, input bit gapped);
        bit accepted;
        int waitCycles;
        if (gapped && $urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
        end
        bgSValid   = 1'b1;
        bgSData    = pix;
        bgSSof     = sof;
        accepted   = 1'b0;
        waitCycles = 0;
        while (!accepted && waitCycles < 100) begin
            @(negedge clk);
            accepted = bgSReady;
            @(posedge clk);
            #1;
            waitCycles++;
        end
        bgSValid = 1'b0;
        bgSSof   = 1'b0;
        if (!accepted) checkOutput("bg_accept_timeout", 64'(accepted), 64'd1);
    endtask

    // Downstream ready for the default instance: random when enabled.
    initial begin
        bgMReady = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bgMReady = bgRandReady ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    // Every transferred block of the default instance is checked against the raster pattern.
    always @(negedge clk) begin
        if (bgMValid && bgMReady) begin
            monK       = bgBlk % BG_BPF;
            monR       = 2 * (monK / (BG_W / 2));
            monC       = 2 * (monK % (BG_W / 2));
            expBlk.p00 = bgPix(monR, monC);
            expBlk.p01 = bgPix(monR, monC + 1);
            expBlk.p10 = bgPix(monR + 1, monC);
            expBlk.p11 = bgPix(monR + 1, monC + 1);
            expEol     = (monC == BG_W - 2);
            expEof     = expEol && (monR == BG_H - 2);
            checkOutput("bg_blk", {30'd0, bgMEof, bgMEol, bgMData}, {30'd0, expEof, expEol, expBlk});
            if (monK == 82) bgBlk82 = bgMData;
            bgBlk++;
        end
    end

    initial begin
        smRstN   = 1'b0;
        smSValid = 1'b0;
        smSData  = '0;
        smSSof   = 1'b0;
        smMReady = 1'b1;
        bgRstN   = 1'b0;
        bgSValid = 1'b0;
        bgSData  = '0;
        bgSSof   = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        checkOutput("rst_m_valid", 64'(smMValid), 64'd0);
        checkOutput("rst_m_data", 64'(smMData), 64'd0);
        checkOutput("rst_m_eol", 64'(smMEol), 64'd0);
        checkOutput("rst_m_eof", 64'(smMEof), 64'd0);
        checkOutput("rst_frame_err", 64'(smFrameErr), 64'd0);
        checkOutput("bg_rst_m_valid", 64'(bgMValid), 64'd0);
        smRstN = 1'b1;
        bgRstN = 1'b1;
        checkOutput("rst_s_ready", 64'(smSReady), 64'd1);

        // 4x2 frame, free-running downstream
        applyStimulus(8'h10, 1'b1);
        for (int i = 1; i < 5; i++) applyStimulus(8'(8'h10 + i), 1'b0);
        applyStimulus(8'h15, 1'b0);
        checkOutput("f1_valid", 64'(smMValid), 64'd1);
        checkOutput("f1_blk0", 64'(smMData), 64'h15141110);
        checkOutput("f1_blk0_eol_eof", {62'd0, smMEol, smMEof}, 64'd0);
        applyStimulus(8'h16, 1'b0);
        checkOutput("f1_valid_drop", 64'(smMValid), 64'd0);
        applyStimulus(8'h17, 1'b0);
        checkOutput("f1_blk1", 64'(smMData), 64'h17161312);
        checkOutput("f1_blk1_eol_eof", {62'd0, smMEol, smMEof}, 64'd3);
        @(posedge clk);
        #1;
        checkOutput("f1_idle_valid", 64'(smMValid), 64'd0);

        // downstream stall with a block pending
        smMReady = 1'b0;
        applyStimulus(8'h40, 1'b1);
        for (int i = 1; i < 6; i++) applyStimulus(8'(8'h40 + i), 1'b0);
        checkOutput("bp_blk0", 64'(smMData), 64'h45444140);
        smSValid = 1'b1;
        smSData  = 8'h46;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            checkOutput("bp_s_ready", 64'(smSReady), 64'd0);
            checkOutput("bp_hold_data", 64'(smMData), 64'h45444140);
            checkOutput("bp_hold_valid", 64'(smMValid), 64'd1);
        end
        smMReady = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("bp_release_valid", 64'(smMValid), 64'd0);
        smSData = 8'h47;
        @(posedge clk);
        #1;
        smSValid = 1'b0;
        checkOutput("bp_blk1", 64'(smMData), 64'h47464342);
        checkOutput("bp_blk1_eol_eof", {62'd0, smMEol, smMEof}, 64'd3);

        // SOF arriving at (1,3) realigns the stream and flags the error
        applyStimulus(8'h20, 1'b1);
        for (int i = 1; i < 7; i++) applyStimulus(8'(8'h20 + i), 1'b0);
        checkOutput("sof_pre_err", 64'(smFrameErr), 64'd0);
        applyStimulus(8'h30, 1'b1);
        checkOutput("sof_err_set", 64'(smFrameErr), 64'd1);
        for (int i = 1; i < 6; i++) applyStimulus(8'(8'h30 + i), 1'b0);
        checkOutput("sof_realign_blk0", 64'(smMData), 64'h35343130);
        applyStimulus(8'h36, 1'b0);
        applyStimulus(8'h37, 1'b0);
        checkOutput("sof_realign_blk1", 64'(smMData), 64'h37363332);
        checkOutput("sof_err_sticky", 64'(smFrameErr), 64'd1);

        // one-cycle reset in the middle of a row
        applyStimulus(8'h50, 1'b1);
        applyStimulus(8'h51, 1'b0);
        applyStimulus(8'h52, 1'b0);
        checkOutput("mr_pre_eol", 64'(smMEol), 64'd1);
        smRstN = 1'b0;
        @(posedge clk);
        #1;
        smRstN = 1'b1;
        checkOutput("mr_m_valid", 64'(smMValid), 64'd0);
        checkOutput("mr_m_data", 64'(smMData), 64'd0);
        checkOutput("mr_eol_eof", {62'd0, smMEol, smMEof}, 64'd0);
        checkOutput("mr_frame_err", 64'(smFrameErr), 64'd0);
        for (int i = 0; i < 6; i++) applyStimulus(8'(8'h60 + i), 1'b0);
        checkOutput("mr_fresh_blk0", 64'(smMData), 64'h65646160);
        applyStimulus(8'h66, 1'b0);
        applyStimulus(8'h67, 1'b0);
        checkOutput("mr_fresh_blk1", 64'(smMData), 64'h67666362);
        checkOutput("mr_fresh_err", 64'(smFrameErr), 64'd0);

        // full default frame, no gaps
        for (int r = 0; r < BG_H; r++)
            for (int c = 0; c < BG_W; c++)
                applyBigStimulus(bgPix(r, c), (r == 0 && c == 0), 1'b0);
        for (int i = 0; i < 50 && bgBlk < BG_BPF; i++) begin
            @(posedge clk);
            #1;
        end
        checkOutput("bg_frame_count", 64'(bgBlk), 64'(BG_BPF));
        checkOutput("bg_blk_r2_c4", 64'(bgBlk82), 64'hE5E44544);
        checkOutput("bg_frame_err", 64'(bgFrameErr), 64'd0);

        // two frames with input gaps and downstream backpressure
        bgRandReady = 1'b1;
        for (int f = 0; f < 2; f++)
            for (int r = 0; r < BG_H; r++)
                for (int c = 0; c < BG_W; c++)
                    applyBigStimulus(bgPix(r, c), (r == 0 && c == 0), 1'b1);
        for (int i = 0; i < 200 && bgBlk < 3 * BG_BPF; i++) begin
            @(posedge clk);
            #1;
        end
        bgRandReady = 1'b0;
        checkOutput("bg_gapped_count", 64'(bgBlk), 64'(3 * BG_BPF));
        checkOutput("bg_gapped_frame_err", 64'(bgFrameErr), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
